req_arbiter: RTL and testbench

- Arbitrates one shared resource among N requesters. Selection uses the team's priority-encode rule (highest set index wins) or a rotating round-robin order.
- Grants are registered, one-hot and held until the owner releases the resource, drops its request, or hits a hold-time limit.
- Sits in front of any shared datapath unit, e.g. a bus port or a shared encoder, and sequences access cycle by cycle.

---
 rtl/req_arbiter.sv | 120 ++++++++++++
 tb/tb_req_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/req_arbiter.sv
// Single-resource arbiter: fixed-priority (highest index) or round-robin selection,
// registered one-hot grant held until done, request drop, or hold-limit timeout.
module req_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 15,
    parameter int IW       = $clog2(N),
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mode,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  done,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;

    logic [IW-1:0] win;
    logic          found;
    int            idx;

    // Winner search: fixed scans upward so the highest set index is kept last;
    // round-robin walks downward from last_id-1, wrapping through N-1.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) win = IW'(i);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = int'(last_q) - k;
                if (idx < 0) idx = idx + N;
                if (!found && req[idx]) begin
                    win   = IW'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    logic rel_done, rel_req, at_limit;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        rel_done  = done[id_q];
        rel_req   = !req[id_q];
        at_limit  = (hold_q == CW'(MAX_HOLD - 1));

        case (state_q)
            IDLE: begin
                gnt_d  = '0;
                id_d   = '0;
                hold_d = '0;
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win;
                    id_d    = win;
                    last_d  = win;
                end
            end
            GRANT: begin
                if (rel_done || rel_req || at_limit) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    id_d      = '0;
                    hold_d    = '0;
                    timeout_d = at_limit && !rel_done && !rel_req;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            last_q    <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed self-checking bench for req_arbiter (N=4, MAX_HOLD=15).
module tb_req_arbiter;

    localparam int N = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          mode;
    logic [N-1:0]  req;
    logic [N-1:0]  done;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          timeout;

    int tests = 0;
    int fails = 0;

    req_arbiter #(.N(4), .MAX_HOLD(15)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mode      (mode),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full output set against an expected grant index (or idle).
    task automatic check_out(input string tag, input bit valid, input int id, input bit tmo);
        logic [N-1:0] eg;
        eg = valid ? (N'(1) << id) : '0;
        check({tag, ".gnt"}, 16'(gnt), 16'(eg));
        check({tag, ".valid"}, 16'(gnt_valid), 16'(valid));
        check({tag, ".id"}, 16'(gnt_id), valid ? 16'(id) : 16'd0);
        check({tag, ".timeout"}, 16'(timeout), 16'(tmo));
    endtask

    initial begin
        int rr_seq [5] = '{3, 2, 1, 0, 3};

        reset_n = 1'b0; mode = 1'b0; req = '0; done = '0;
        tick(); tick();
        check_out("reset", 0, 0, 0);
        reset_n = 1'b1;
        tick();
        check_out("idle_noreq", 0, 0, 0);

        // Fixed priority pick and done release
        req = 4'b0110;
        tick();
        check_out("fixed_0110", 1, 2, 0);
        done = 4'b0100;
        tick();
        check_out("done_release", 0, 0, 0);
        done = '0; req = '0;
        tick();

        // Round-robin rotation from a fresh last_id
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; mode = 1'b1; req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            check_out($sformatf("rr_grant%0d", i), 1, rr_seq[i], 0);
            done = N'(1) << rr_seq[i];
            tick();
            check_out($sformatf("rr_gap%0d", i), 0, 0, 0);
            done = '0;
            if (i < 4) tick();
        end
        req = '0; mode = 1'b0;
        tick();

        // Hold limit timeout
        req = 4'b0001;
        tick();
        for (int i = 0; i < 15; i++) begin
            check_out($sformatf("hold%0d", i), 1, 0, 0);
            tick();
        end
        check_out("limit_timeout", 0, 0, 1);
        tick();
        check_out("regrant_after_timeout", 1, 0, 0);

        // done coinciding with the limit is a normal release
        for (int i = 0; i < 14; i++) tick();
        check_out("hold15_again", 1, 0, 0);
        done = 4'b0001;
        tick();
        check_out("done_at_limit", 0, 0, 0);
        done = '0; req = '0;
        tick();

        // Owner drops request; remaining requester wins after gap
        req = 4'b1011;
        tick();
        check_out("grant3", 1, 3, 0);
        mode = 1'b1;
        req = 4'b0011;
        tick();
        check_out("req_drop", 0, 0, 0);
        mode = 1'b0;
        tick();
        check_out("fixed_after_drop", 1, 1, 0);
        req = '0;
        tick();
        check_out("drop_release", 0, 0, 0);

        // Reset mid-grant clears last_id
        req = 4'b0010;
        tick();
        check_out("grant1", 1, 1, 0);
        tick();
        reset_n = 1'b0;
        tick();
        check_out("mid_reset", 0, 0, 0);
        reset_n = 1'b1; mode = 1'b1; req = 4'b0101;
        tick();
        check_out("rr_after_reset", 1, 2, 0);
        req = '0;
        tick();
        check_out("final_release", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
